// File: rtl/conv_mem_streamer.sv
// Word-burst OBI sequencer for the conv/max-pool accelerator: reads feed its data-load phases,
// writes drain its write-back phases, and cnt_o is the shared word index the accelerator follows.
//   state    | meaning
//   IDLE     | waiting for start_rd_i / start_wr_i
//   REQ      | request presented, held stable until data_gnt_i
//   WAIT_RSP | request accepted, waiting for data_rvalid_i
//   DONE     | one-cycle completion pulse, back to IDLE
module conv_mem_streamer #(
  parameter int MAX_WORDS = 16,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_rd_i,
  input  logic             start_wr_i,
  input  logic [31:0]      base_addr_i,
  input  logic [4:0]       nwords_i,
  input  logic [31:0]      wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic [31:0]      rdata_o,
  output logic             rdata_valid_o,
  output logic             data_req_o,
  input  logic             data_gnt_i,
  output logic [31:0]      data_addr_o,
  output logic             data_we_o,
  output logic [3:0]       data_be_o,
  output logic [31:0]      data_wdata_o,
  input  logic             data_rvalid_i,
  input  logic [31:0]      data_rdata_i
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REQ      = 2'd1;
  localparam logic [1:0] WAIT_RSP = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]       state;
  logic [4:0]       idx;
  logic [4:0]       len;
  logic [31:0]      base;
  logic             we;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rdata_q;
  logic             rvalid_q;
  logic [4:0]       len_clamp;
  logic [4:0]       idx_nxt;

  assign len_clamp = (nwords_i > 5'(MAX_WORDS)) ? 5'(MAX_WORDS) : nwords_i;
  assign idx_nxt   = idx + 5'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      len      <= '0;
      base     <= '0;
      we       <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_rd_i || start_wr_i) begin
            base  <= base_addr_i;
            len   <= len_clamp;
            we    <= ~start_rd_i;
            idx   <= '0;
            cnt_q <= '0;
            state <= (len_clamp == 5'd0) ? DONE : REQ;
          end
        end
        REQ: begin
          if (data_gnt_i) state <= WAIT_RSP;
        end
        WAIT_RSP: begin
          if (data_rvalid_i) begin
            idx   <= idx_nxt;
            cnt_q <= CNT_W'(idx_nxt);
            // rdata_valid_o lands with the cnt_o update, so cnt_o = k pairs with word k-1
            if (!we) begin
              rdata_q  <= data_rdata_i;
              rvalid_q <= 1'b1;
            end
            state <= (idx_nxt == len) ? DONE : REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o        = (state != IDLE);
  assign done_o        = (state == DONE);
  assign cnt_o         = cnt_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rvalid_q;

  assign data_req_o   = (state == REQ);
  assign data_addr_o  = data_req_o ? (base + {25'd0, idx, 2'b00}) : 32'd0;
  assign data_we_o    = data_req_o & we;
  assign data_be_o    = data_req_o ? 4'hF : 4'h0;
  assign data_wdata_o = data_req_o ? wdata_i : 32'd0;

endmodule

// File: tb/tb_conv_mem_streamer.sv
// Scoreboard bench for conv_mem_streamer: a burst model queues expected bus requests, read
// results and completion times; a monitor pops them as the DUT presents them.
module tb_conv_mem_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_rd_i = 1'b0;
  logic        start_wr_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [4:0]  nwords_i = '0;
  logic [31:0] wdata_i;
  logic        busy_o, done_o, rdata_valid_o;
  logic [31:0] cnt_o, rdata_o;
  logic        data_req_o, data_we_o;
  logic        data_gnt_i = 1'b0;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_addr_o, data_wdata_o;
  logic [31:0] data_rdata_i = '0;
  logic [3:0]  data_be_o;

  conv_mem_streamer dut (
    .clk(clk), .rst_n(rst_n), .start_rd_i(start_rd_i), .start_wr_i(start_wr_i),
    .base_addr_i(base_addr_i), .nwords_i(nwords_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .done_o(done_o), .cnt_o(cnt_o), .rdata_o(rdata_o),
    .rdata_valid_o(rdata_valid_o), .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
    .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
  );

  always #5 clk = ~clk;

  // accelerator side: word k of the write-back is key + k
  logic [31:0] wkey = '0;
  assign wdata_i = wkey + cnt_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_len = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata;} txn_t;
  typedef struct {int cnt; logic [31:0] data;} rd_t;
  typedef struct {int cyc; int len;} done_t;
  txn_t  exp_txn[$];
  rd_t   exp_rd[$];
  done_t exp_done[$];
  int    stall_q[$];
  int    lat_q[$];
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic void unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: DUT event with nothing expected (cycle %0d)", name, cyc);
  endfunction

  // monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_req_o) begin
        if (exp_txn.size() == 0) unexpected("req");
        else begin
          chk("addr", data_addr_o, exp_txn[0].addr);
          chk("we", 32'(data_we_o), 32'(exp_txn[0].we));
          chk("be", 32'(data_be_o), 32'hF);
          if (exp_txn[0].we) chk("wdata", data_wdata_o, exp_txn[0].wdata);
          if (data_gnt_i) void'(exp_txn.pop_front());
        end
      end else if (data_be_o != 4'h0) chk("be_idle", 32'(data_be_o), 32'h0);
      if (rdata_valid_o) begin
        if (exp_rd.size() == 0) unexpected("rdata_valid");
        else begin
          chk("rd_cnt", cnt_o, 32'(exp_rd[0].cnt));
          chk("rdata", rdata_o, exp_rd[0].data);
          void'(exp_rd.pop_front());
        end
      end
      if (done_o) begin
        if (exp_done.size() == 0) unexpected("done");
        else begin
          chk("done_cycle", 32'(cyc), 32'(exp_done[0].cyc));
          chk("done_cnt", cnt_o, 32'(exp_done[0].len));
          chk("done_busy", 32'(busy_o), 32'h1);
          void'(exp_done.pop_front());
        end
      end
    end
  end

  // memory: grant after the queued stall, respond lat WAIT cycles later, spurious rvalid when idle
  initial begin
    int phase, scnt, wcnt, cur_stall, cur_lat;
    logic [31:0] cur_addr;
    logic cur_we;
    phase = 0; scnt = 0; wcnt = 0; cur_stall = 0; cur_lat = 1; cur_addr = '0; cur_we = 1'b0;
    forever begin
      @(posedge clk); #1;
      data_gnt_i = 1'b0;
      data_rvalid_i = 1'b0;
      data_rdata_i = $urandom;
      if (!rst_n) begin
        phase = 0;
        continue;
      end
      if (phase == 0 && data_req_o) begin
        if (stall_q.size() == 0) begin
          cur_stall = 0; cur_lat = 1;
        end else begin
          cur_stall = stall_q.pop_front();
          cur_lat = lat_q.pop_front();
        end
        scnt = 0;
        phase = 1;
      end
      if (phase == 1) begin
        if (scnt == cur_stall) begin
          data_gnt_i = 1'b1;
          cur_addr = data_addr_o;
          cur_we = data_we_o;
          if (cur_we) mem[cur_addr] = data_wdata_o;
          wcnt = 0;
          phase = 2;
        end else begin
          scnt++;
          data_rvalid_i = ($urandom_range(3) == 0);
        end
      end else if (phase == 2) begin
        wcnt++;
        if (wcnt == cur_lat) begin
          data_rvalid_i = 1'b1;
          if (!cur_we) data_rdata_i = mem_rd(cur_addr);
          phase = 0;
        end
      end else if (!data_req_o) data_rvalid_i = ($urandom_range(3) == 0);
    end
  end

  // stall_word: -1 none, -2 random per word; lat_fix 0 = random 1..3
  task automatic launch(input bit rd, input bit wr, input logic [31:0] base, input logic [4:0] n,
                        input int stall_word, input int stall_len, input int lat_fix,
                        input logic [31:0] key);
    int len, t, st, lt;
    logic [31:0] a;
    len = (n > 5'd16) ? 16 : int'(n);
    t = 0;
    wkey = key;
    for (int i = 0; i < len; i++) begin
      a = base + 32'(4 * i);
      if (stall_word == -2) st = ($urandom_range(3) == 0) ? int'($urandom_range(1, 4)) : 0;
      else st = (i == stall_word) ? stall_len : 0;
      lt = (lat_fix == 0) ? int'($urandom_range(1, 3)) : lat_fix;
      exp_txn.push_back('{a, !rd, key + 32'(i)});
      if (rd) exp_rd.push_back('{i + 1, mem_rd(a)});
      stall_q.push_back(st);
      lat_q.push_back(lt);
      t += st + 1 + lt;
    end
    @(posedge clk); #1;
    start_rd_i = rd; start_wr_i = wr; base_addr_i = base; nwords_i = n;
    exp_done.push_back('{cyc + 1 + t, len});
    last_len = len;
    @(posedge clk); #1;
    start_rd_i = 1'b0; start_wr_i = 1'b0; base_addr_i = $urandom; nwords_i = 5'($urandom);
    chk("busy_after_start", 32'(busy_o), 32'h1);
    chk("cnt_cleared", cnt_o, 32'h0);
  endtask

  task automatic finish_burst(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((busy_o || exp_done.size() != 0) && k < 400);
    if (k >= 400) unexpected({name, "_timeout"});
    chk({name, "_txn_left"}, 32'(exp_txn.size()), 32'h0);
    chk({name, "_rd_left"}, 32'(exp_rd.size()), 32'h0);
    chk({name, "_cnt_hold"}, cnt_o, 32'(last_len));
  endtask

  initial begin
    int k;
    logic rd, wr;
    logic [31:0] b;
    #3;
    chk("rst_busy", 32'(busy_o), 0); chk("rst_done", 32'(done_o), 0);
    chk("rst_req", 32'(data_req_o), 0); chk("rst_cnt", cnt_o, 0);
    chk("rst_rdata", rdata_o, 0); chk("rst_rvalid", 32'(rdata_valid_o), 0);
    chk("rst_addr", data_addr_o, 0); chk("rst_be", 32'(data_be_o), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) mem[32'h1000 + 32'(4 * i)] = 32'(i * 3);
    launch(1, 0, 32'h1000, 5'd16, -1, 0, 2, 32'h0);           // done 49 cycles after start
    finish_burst("read16");
    launch(0, 1, 32'h3000, 5'd4, -1, 0, 1, 32'hA0);
    finish_burst("write4");
    launch(1, 0, 32'h4000, 5'd4, 2, 5, 2, 32'h0);             // 5 no-grant cycles on word 2
    finish_burst("backpressure");
    launch(0, 1, 32'h5000, 5'd0, -1, 0, 1, 32'h0);
    finish_burst("zero_len");
    launch(1, 0, 32'h6000, 5'd31, -2, 0, 0, 32'h0);
    finish_burst("clamp31");
    launch(0, 1, 32'hFFFF_FFF8, 5'd4, -1, 0, 1, 32'h1234_0000);
    finish_burst("addr_wrap");
    launch(1, 1, 32'h7000, 5'd3, -1, 0, 1, 32'h0);
    finish_burst("collision");

    launch(1, 0, 32'h8000, 5'd6, -1, 0, 2, 32'h0);
    repeat (3) @(posedge clk);
    #1 start_wr_i = 1'b1; base_addr_i = 32'h9000; nwords_i = 5'd8;
    @(posedge clk);
    #1 start_wr_i = 1'b0;
    finish_burst("start_while_busy");

    launch(1, 0, 32'h2000, 5'd8, -1, 0, 3, 32'h0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(data_req_o && data_gnt_i && data_addr_o == 32'h2010) && k < 200);
    if (k >= 200) unexpected("reset_wait_timeout");
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(data_req_o), 0); chk("midrst_busy", 32'(busy_o), 0);
    chk("midrst_cnt", cnt_o, 0); chk("midrst_done", 32'(done_o), 0);
    exp_txn.delete(); exp_rd.delete(); exp_done.delete(); stall_q.delete(); lat_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    launch(1, 0, 32'h2000, 5'd4, -1, 0, 1, 32'h0);
    finish_burst("after_reset");

    for (int n = 0; n < 25; n++) begin
      rd = 1'($urandom);
      wr = rd ? 1'($urandom) : 1'b1;
      b = {$urandom_range(3) == 0 ? 28'hFFF_FFFF : 28'($urandom), 4'h0} & 32'hFFFF_FFFC;
      launch(rd, wr, b, 5'($urandom_range(0, 31)), -2, 0, 0, $urandom);
      finish_burst("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
